// File: rtl/isqrt_pkg.sv
// Shared types and default widths for the isqrt32 integer square root block.
package isqrt_pkg;

   // Default radicand width (must be even) and the matching root width.
   localparam int DIN_W_DEF  = 32;
   localparam int ROOT_W_DEF = DIN_W_DEF / 2;

   // Controller states: idle, iterating one root bit per cycle, result pulse.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } isqrt_state_t;

endpackage

// File: rtl/isqrt_step.sv
// One restoring square-root iteration: bring in two radicand bits, try the
// trial divisor (root<<2)|1, and resolve the next root bit.
// The remainder is ROOT_W+2 bits wide so the final step cannot overflow.
module isqrt_step #(
   parameter int ROOT_W = 16
) (
   input  logic [ROOT_W+1:0] rem_i,
   input  logic [ROOT_W-1:0] root_i,
   input  logic [1:0]        bits_i,
   output logic [ROOT_W+1:0] rem_o,
   output logic [ROOT_W-1:0] root_o
);

   logic [ROOT_W+1:0] rem_sh;
   logic [ROOT_W+1:0] trial;
   logic              take;

   // Shift in the next radicand pair, compare against the trial value and
   // either subtract (root bit 1) or keep the remainder (root bit 0).
   always_comb begin
      rem_sh = (rem_i << 2) | {{ROOT_W{1'b0}}, bits_i};
      trial  = {root_i, 2'b01};
      take   = (rem_sh >= trial);
      rem_o  = take ? (rem_sh - trial) : rem_sh;
      root_o = (root_i << 1) | {{(ROOT_W-1){1'b0}}, take};
   end

endmodule

// File: rtl/isqrt32.sv
// Sequential integer square root, one root bit per clock, MSB first.
// Handshake: start is accepted in IDLE or DONE (din sampled on that edge);
// busy is high for the ROOT_W iteration cycles, then done pulses for one
// cycle with dout/rem valid; dout/rem hold until the next done pulse.
// Optional macro ISQRT_ROUND_EN rounds dout to nearest (rem stays truncated).
module isqrt32
   import isqrt_pkg::*;
#(
   parameter int DIN_W  = DIN_W_DEF,
   parameter int ROOT_W = DIN_W / 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DIN_W-1:0]  din,
   output logic              busy,
   output logic              done,
   output logic [ROOT_W-1:0] dout,
   output logic [ROOT_W:0]   rem,
   output isqrt_state_t      state_dbg_o
);

   localparam int CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

   isqrt_state_t      state_q, state_d;
   logic [DIN_W-1:0]  rad_q,   rad_d;
   logic [ROOT_W-1:0] root_q,  root_d;
   logic [ROOT_W+1:0] prem_q,  prem_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic [ROOT_W-1:0] dout_q,  dout_d;
   logic [ROOT_W:0]   rem_q,   rem_d;

   logic [ROOT_W+1:0] step_rem;
   logic [ROOT_W-1:0] step_root;
   logic [ROOT_W-1:0] final_root;

   // Single shared iteration step, fed from the partial root/remainder and
   // the top two bits of the shifting radicand register.
   isqrt_step #(.ROOT_W(ROOT_W)) u_step (
      .rem_i  (prem_q),
      .root_i (root_q),
      .bits_i (rad_q[DIN_W-1 -: 2]),
      .rem_o  (step_rem),
      .root_o (step_root)
   );

`ifdef ISQRT_ROUND_EN
   // Round to nearest: bump the root when the remainder exceeds it,
   // but never wrap past the largest representable root.
   always_comb begin
      final_root = step_root;
      if ((step_rem > {2'b00, step_root}) && (step_root != {ROOT_W{1'b1}})) begin
         final_root = step_root + 1'b1;
      end
   end
`else
   // Floor root is delivered unchanged.
   always_comb begin
      final_root = step_root;
   end
`endif

   // Next-state and datapath update for the IDLE/CALC/DONE controller.
   always_comb begin
      state_d = state_q;
      rad_d   = rad_q;
      root_d  = root_q;
      prem_d  = prem_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      rem_d   = rem_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               rad_d   = din;
               root_d  = '0;
               prem_d  = '0;
               cnt_d   = CNT_W'(ROOT_W - 1);
               state_d = CALC;
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            root_d = step_root;
            prem_d = step_rem;
            rad_d  = rad_q << 2;
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               // Last bit resolved: publish results as DONE is entered.
               dout_d  = final_root;
               rem_d   = step_rem[ROOT_W:0];
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, all cleared by the asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rad_q   <= '0;
         root_q  <= '0;
         prem_q  <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         rad_q   <= rad_d;
         root_q  <= root_d;
         prem_q  <= prem_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         rem_q   <= rem_d;
      end
   end

   assign busy        = (state_q == CALC);
   assign done        = (state_q == DONE);
   assign dout        = dout_q;
   assign rem         = rem_q;
   assign state_dbg_o = state_q;

endmodule
